fp_mac_dot_seq: RTL and testbench



---
 rtl/fp_mac_dot_seq.sv | 208 ++++++++++++++++++++
 tb/tb_fp_mac_dot_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mac_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_mac_dot_seq
// Purpose  : Sequential dot-product controller for an external combinational
//            floating-point multiply-accumulate unit (z = a*b + c). Accepts a
//            stream of (a, b) element pairs and feeds the MAC from registered
//            operands, with c taken from its own accumulator. It captures
//            z/status every active cycle and returns the final sum, the OR of
//            all status flags and the element count on a result handshake.
//
// Ports    : clk, rst                    clock, synchronous active-high reset
//            in_valid/in_ready           element handshake
//            in_a, in_b, in_last         element operands, end-of-vector mark
//            in_bias                     initial accumulator value (optional)
//            rnd                         rounding mode, taken on first element
//            mac_a/b/c, mac_rnd          operands driven to the MAC
//            mac_z, mac_status           MAC result and status flags
//            res_valid/res_ready         result handshake
//            res_z, res_status, res_count  dot product, OR of flags, count
//
// Options  : define FP_DOT_SEQ_BIAS_EN to add the in_bias port. The
//            accumulator then starts at in_bias instead of +0.
//
// Revision : 1.0  initial release
// ============================================================================
module fp_mac_dot_seq #(
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int cnt_width = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [sig_width+exp_width:0]   in_a,
  input  logic [sig_width+exp_width:0]   in_b,
`ifdef FP_DOT_SEQ_BIAS_EN
  input  logic [sig_width+exp_width:0]   in_bias,
`endif
  input  logic                           in_last,
  input  logic [2:0]                     rnd,
  output logic [sig_width+exp_width:0]   mac_a,
  output logic [sig_width+exp_width:0]   mac_b,
  output logic [sig_width+exp_width:0]   mac_c,
  output logic [2:0]                     mac_rnd,
  input  logic [sig_width+exp_width:0]   mac_z,
  input  logic [7:0]                     mac_status,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [sig_width+exp_width:0]   res_z,
  output logic [7:0]                     res_status,
  output logic [cnt_width-1:0]           res_count
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ACCUM = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]                    r_state;
  logic [1:0]                    w_state_next;

  logic [sig_width+exp_width:0]  r_op_a;
  logic [sig_width+exp_width:0]  r_op_b;
  logic [sig_width+exp_width:0]  r_acc;
  logic [2:0]                    r_rnd;
  logic                          r_op_valid;
  logic                          r_last;
  logic [7:0]                    r_stat;
  logic [cnt_width-1:0]          r_count;
  logic [sig_width+exp_width:0]  r_res_z;
  logic [7:0]                    r_res_status;
  logic [cnt_width-1:0]          r_res_count;

  logic                          w_in_fire;
  logic                          w_capture;
  logic [cnt_width-1:0]          w_count_inc;
  logic [7:0]                    w_stat_next;
  logic [sig_width+exp_width:0]  w_acc_init;

  // Starting value of the running sum for a new vector.
`ifdef FP_DOT_SEQ_BIAS_EN
  assign w_acc_init = in_bias;
`else
  assign w_acc_init = '0;
`endif

  assign w_in_fire   = in_valid & in_ready;
  // The MAC is purely combinational, so whenever registered operands are
  // present its z output already belongs to them and can be taken this cycle.
  assign w_capture   = r_op_valid & (r_state == c_ACCUM);
  assign w_count_inc = (&r_count) ? r_count
                                  : r_count + {{(cnt_width-1){1'b0}}, 1'b1};
  assign w_stat_next = r_stat | mac_status;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_in_fire) w_state_next = c_ACCUM;
      end
      c_ACCUM: begin
        if (w_capture && r_last) w_state_next = c_DONE;
      end
      c_DONE: begin
        if (res_ready) w_state_next = c_IDLE;
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      c_IDLE:  in_ready  = 1'b1;
      // Once the final element is held, stop taking input until the result
      // has been handed off.
      c_ACCUM: in_ready  = ~r_last;
      c_DONE:  res_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand, accumulator and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_acc        <= '0;
      r_rnd        <= '0;
      r_op_valid   <= 1'b0;
      r_last       <= 1'b0;
      r_stat       <= '0;
      r_count      <= '0;
      r_res_z      <= '0;
      r_res_status <= '0;
      r_res_count  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_in_fire) begin
            r_op_a     <= in_a;
            r_op_b     <= in_b;
            r_rnd      <= rnd;
            r_op_valid <= 1'b1;
            r_last     <= in_last;
            r_acc      <= w_acc_init;
            r_stat     <= '0;
            r_count    <= '0;
          end
        end
        c_ACCUM: begin
          if (w_capture) begin
            r_acc   <= mac_z;
            r_stat  <= w_stat_next;
            r_count <= w_count_inc;
            // Publish the freshly captured values, not the stale registers.
            if (r_last) begin
              r_res_z      <= mac_z;
              r_res_status <= w_stat_next;
              r_res_count  <= w_count_inc;
            end
          end
          // rnd is deliberately not reloaded here: it is fixed per vector.
          if (w_in_fire) begin
            r_op_a     <= in_a;
            r_op_b     <= in_b;
            r_op_valid <= 1'b1;
            r_last     <= in_last;
          end else if (w_capture) begin
            r_op_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mac_a      = r_op_a;
  assign mac_b      = r_op_b;
  assign mac_c      = r_acc;
  assign mac_rnd    = r_rnd;
  assign res_z      = r_res_z;
  assign res_status = r_res_status;
  assign res_count  = r_res_count;

endmodule
`default_nettype wire

// File: tb/tb_fp_mac_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mac_dot_seq
// Purpose  : Self-checking bench for fp_mac_dot_seq. Provides a behavioural
//            single-precision MAC for the DUT to drive, issues directed and
//            random vectors, and checks every result against a scoreboard of
//            expected sums computed with real arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_mac_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_bias;
  logic        in_last;
  logic [2:0]  rnd;
  logic [31:0] mac_a;
  logic [31:0] mac_b;
  logic [31:0] mac_c;
  logic [2:0]  mac_rnd;
  logic [31:0] mac_z;
  logic [7:0]  mac_status;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_z;
  logic [7:0]  res_status;
  logic [15:0] res_count;

  int tests  = 0;
  int errors = 0;
  bit rr_rand = 1'b0;

  typedef struct packed {
    logic [31:0] z;
    logic [7:0]  st;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  logic [31:0] va[64];
  logic [31:0] vb[64];

  fp_mac_dot_seq #(
    .sig_width(23),
    .exp_width(8),
    .cnt_width(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef FP_DOT_SEQ_BIAS_EN
    .in_bias    (in_bias),
`endif
    .in_last    (in_last),
    .rnd        (rnd),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_c      (mac_c),
    .mac_rnd    (mac_rnd),
    .mac_z      (mac_z),
    .mac_status (mac_status),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_z      (res_z),
    .res_status (res_status),
    .res_count  (res_count)
  );

  always #5 clk = ~clk;

  // Single-precision bits to real; denormals treated as zero, inf as huge.
  function automatic real f2r(input logic [31:0] x);
    int  e;
    real m;
    real r;
    e = int'(x[30:23]);
    if (e == 0) return 0.0;
    if (e == 255) r = 1.0e300;
    else begin
      m = 1.0 + real'(x[22:0]) / 8388608.0;
      r = m * (2.0 ** real'(e - 127));
    end
    return x[31] ? -r : r;
  endfunction

  // Real to single precision (round to nearest even) with MAC-style flags:
  // bit0 zero, bit1 infinity, bit3 tiny, bit4 huge, bit5 inexact.
  function automatic void r2f(input real v, output logic [31:0] z,
                              output logic [7:0] st);
    logic [63:0] d;
    logic        s;
    int          e;
    logic [52:0] m;
    logic [23:0] mt;
    logic [28:0] rem;
    logic        rup;
    logic [24:0] ms;
    d = $realtobits(v);
    s = d[63];
    e = int'(d[62:52]) - 1023;
    m = {1'b1, d[51:0]};
    if (v == 0.0) begin
      z  = {s, 31'd0};
      st = 8'h01;
    end else if (e < -126) begin
      z  = {s, 31'd0};
      st = 8'h29;
    end else begin
      mt  = m[52:29];
      rem = m[28:0];
      rup = rem[28] && ((rem[27:0] != 28'd0) || mt[0]);
      ms  = {1'b0, mt} + {24'd0, rup};
      if (ms[24]) begin
        ms = ms >> 1;
        e  = e + 1;
      end
      if (e > 127) begin
        z  = {s, 8'hFF, 23'd0};
        st = 8'h32;
      end else begin
        z  = {s, 8'(e + 127), ms[22:0]};
        st = (rem != 29'd0) ? 8'h20 : 8'h00;
      end
    end
  endfunction

  // Behavioural combinational MAC attached to the DUT.
  always_comb begin
    r2f(f2r(mac_a) * f2r(mac_b) + f2r(mac_c), mac_z, mac_status);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] z, input logic [7:0] st,
                      input logic [15:0] cnt);
    exp_t e;
    e.z = z; e.st = st; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Reference: bias + sum of products in real arithmetic; status is the OR of
  // the flags of every rounded partial sum.
  task automatic push_model(input int n, input logic [31:0] bias);
    real         s;
    logic [31:0] z;
    logic [7:0]  f;
    logic [7:0]  st;
    s  = f2r(bias);
    st = 8'h00;
    z  = 32'd0;
    for (int i = 0; i < n; i++) begin
      s = s + f2r(va[i]) * f2r(vb[i]);
      r2f(s, z, f);
      st = st | f;
    end
    push(z, st, 16'(n));
  endtask

  // Result monitor: compares whenever a result transfers.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_result: got z=%h, expected no result", res_z);
      end else begin
        e = sb.pop_front();
        chk("res_z", res_z, e.z);
        chk("res_status", {24'd0, res_status}, {24'd0, e.st});
        chk("res_count", {16'd0, res_count}, {16'd0, e.cnt});
      end
    end
  end

  // Random result back-pressure during the random phase.
  always @(posedge clk) begin
    if (rr_rand) begin
      #1 res_ready = 1'($urandom_range(0, 1));
    end
  end

  // Offers one element starting at posedge+1; returns at posedge+1 after the
  // transfer edge with in_valid dropped.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic last, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      tests++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (res_valid) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      errors++;
      $display("FAIL res_timeout: res_valid=%b, expected 1", res_valid);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          n;
    int          k;
    logic [2:0]  r;
    logic [7:0]  fdum;
    logic [31:0] one;
    one      = 32'h3F800000;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
    in_bias  = '0;
    rnd      = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_z", res_z, 32'd0);
    chk("rst_res_status", {24'd0, res_status}, 32'd0);
    chk("rst_res_count", {16'd0, res_count}, 32'd0);
    chk("rst_mac_c", mac_c, 32'd0);
    @(posedge clk); #1;

    // Two-element vector 1*2 + 3*1 with latency check
    push(32'h40A00000, 8'h00, 16'd2);
    send(32'h3F800000, 32'h40000000, 1'b0, w);
    send(32'h40400000, 32'h3F800000, 1'b1, w);
    @(negedge clk);
    chk("lat_cycle1_res_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2_res_valid", {31'd0, res_valid}, 32'd1);
    drain();

    // Single element
    push(32'h40C00000, 8'h00, 16'd1);
    send(32'h40000000, 32'h40400000, 1'b1, w);
    drain();

    // Back-to-back four elements with result stall
    res_ready = 1'b0;
    push(32'h40800000, 8'h00, 16'd4);
    for (int i = 0; i < 4; i++) begin
      send(one, one, (i == 3), w);
      chk("b2b_wait_cycles", 32'(w), 32'd0);
    end
    wait_res();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_res_z", res_z, 32'h40800000);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    drain();

    // Overflow: flags appear and remain while the next vector starts
    push(32'h7F800000, 8'h32, 16'd1);
    send(32'h7F000000, 32'h7F000000, 1'b1, w);
    drain();
    push(32'h40000000, 8'h00, 16'd2);
    send(one, one, 1'b0, w);
    @(negedge clk);
    chk("ovf_flags_held", {24'd0, res_status & 8'h30}, 32'h30);
    @(posedge clk); #1;
    send(one, one, 1'b1, w);
    drain();

    // Reset in the middle of a vector
    send(one, one, 1'b0, w);
    send(one, one, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_res_count", {16'd0, res_count}, 32'd0);
    @(posedge clk); #1;
    push(32'h3F800000, 8'h00, 16'd1);
    send(one, one, 1'b1, w);
    drain();

`ifdef FP_DOT_SEQ_BIAS_EN
    in_bias = 32'h40000000;
    push(32'h40400000, 8'h00, 16'd1);
    send(one, one, 1'b1, w);
    drain();
    in_bias = '0;
`endif

    // Random vectors of quarter-integer operands (exact in single precision)
    rr_rand = 1'b1;
    for (int v = 0; v < 25; v++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(1, 16);
        r2f(real'(k) / 4.0, va[i], fdum);
        k = $urandom_range(1, 16);
        r2f(real'(k) / 4.0, vb[i], fdum);
      end
      push_model(n, in_bias);
      r = 3'($urandom_range(0, 7));
      rnd = r;
      for (int i = 0; i < n; i++) begin
        send(va[i], vb[i], (i == n - 1), w);
        if (i == 0) begin
          rnd = 3'($urandom_range(0, 7));
          if (n > 1) begin
            @(negedge clk);
            chk("mac_rnd_held", {29'd0, mac_rnd}, {29'd0, r});
            @(posedge clk); #1;
          end
        end
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      rnd = '0;
    end
    rr_rand = 1'b0;
    @(posedge clk);
    #2 res_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
